// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        BRANCH = 2'd0,
        JAL    = 2'd1,
        JALR   = 2'd2
    } redirect_type_e;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int ILEN16_STEP = 2;
    localparam int ILEN32_STEP = 4;

endpackage

// File: rtl/pc_register_sync.sv
// Program-counter register with synchronous active-high reset and write enable.
module pc_register_sync #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            we,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    always_ff @(posedge clk) begin
        if (srst) begin
            q <= RESET_VALUE;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_pc_controller.sv
// Fetch PC controller: next-PC selection, stalled-redirect holding, flush and misalignment flags.
module fetch_pc_controller
    import fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter bit              COMPRESSED   = 1'b1
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            stallIF,
    input  logic            instrIsCompressed,
    input  logic            redirectValid,
    input  redirect_type_e  redirectType,
    input  logic [XLEN-1:0] redirectBase,
    input  logic [XLEN-1:0] redirectOffset,
    input  logic            trapValid,
    input  logic [XLEN-1:0] trapVector,
    output logic [XLEN-1:0] pcIF,
    output logic [XLEN-1:0] pcLink,
    output logic            flushIF,
    output logic            flushID,
    output logic            misaligned,
    output logic [XLEN-1:0] misalignedTval,
    output state_e          fsmState
);

    // redirectValid and trapValid are single-cycle valid-only requests: there is no
    // ready back-pressure, so a request is either accepted in the cycle it is presented
    // (and parked in pendingPc if fetch is stalled) or dropped (misaligned / lost to a trap).

    state_e          state, stateNext;
    logic [XLEN-1:0] pendingPc;
    logic            pendingWe;
    logic            pcWe;
    logic [XLEN-1:0] pcNext;
    logic [XLEN-1:0] step;
    logic [XLEN-1:0] rawTarget;
    logic [XLEN-1:0] target;
    logic            targetMisaligned;
    logic            redirectOk;
    logic            accept;
    logic [XLEN-1:0] acceptTarget;

    assign step      = (COMPRESSED && instrIsCompressed) ? XLEN'(ILEN16_STEP) : XLEN'(ILEN32_STEP);
    assign pcLink    = pcIF + step;
    assign rawTarget = redirectBase + redirectOffset;
    assign target    = (redirectType == JALR) ? {rawTarget[XLEN-1:1], 1'b0} : rawTarget;

    assign targetMisaligned = target[0] || (!COMPRESSED && target[1]);
    assign redirectOk       = redirectValid && !targetMisaligned;
    assign accept           = trapValid || redirectOk;
    assign acceptTarget     = trapValid ? trapVector : target;

    // A trap swallows a simultaneous redirect, including its misalignment report.
    assign misaligned     = redirectValid && !trapValid && targetMisaligned;
    assign misalignedTval = target;

    assign flushIF  = accept || (state == HOLD);
    assign flushID  = accept;
    assign fsmState = state;

    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= RUN;
            pendingPc <= '0;
        end else begin
            state <= stateNext;
            if (pendingWe) begin
                pendingPc <= acceptTarget;
            end
        end
    end

    always_comb begin
        stateNext = state;
        pendingWe = 1'b0;
        pcWe      = 1'b0;
        pcNext    = pcIF + step;
        case (state)
            RUN: begin
                if (accept && stallIF) begin
                    pendingWe = 1'b1;
                    stateNext = HOLD;
                end else if (accept) begin
                    pcWe   = 1'b1;
                    pcNext = acceptTarget;
                end else if (!stallIF) begin
                    pcWe = 1'b1;
                end
            end
            HOLD: begin
                if (stallIF) begin
                    pendingWe = accept;
                end else begin
                    pcWe      = 1'b1;
                    pcNext    = accept ? acceptTarget : pendingPc;
                    stateNext = RUN;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    pc_register_sync #(
        .XLEN       (XLEN),
        .RESET_VALUE(RESET_VECTOR)
    ) u_pcReg (
        .clk (clk),
        .srst(srst),
        .we  (pcWe),
        .d   (pcNext),
        .q   (pcIF)
    );

endmodule
